// File: rtl/seq_chunk_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through a registered carry.
// Define SEQ_ADDSUB_SUB_EN to let op select subtract; otherwise it always adds.
module seq_chunk_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic             c0_eff;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;
    logic             c_msb;

`ifdef SEQ_ADDSUB_SUB_EN
    assign b_eff  = op ? ~y : y;
    assign c0_eff = op ? 1'b1 : cin;
`else
    logic op_unused;
    assign op_unused = op;
    assign b_eff     = y;
    assign c0_eff    = cin;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        a_chunk = a_q[k_q*CHUNK +: CHUNK];
        b_chunk = b_q[k_q*CHUNK +: CHUNK];
        sum     = {1'b0, a_chunk} + {1'b0, b_chunk}
                + {{CHUNK{1'b0}}, carry_q};
        // Carry into the MSB of this chunk, recovered from the sum bit
        c_msb   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum[CHUNK-1];

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = x;
                    b_d     = b_eff;
                    carry_d = c0_eff;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[k_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
                carry_d = sum[CHUNK];
                if (k_q == K_LAST) begin
                    cout_d  = sum[CHUNK];
                    ovf_d   = c_msb ^ sum[CHUNK];
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_addsub.sv
// Directed bench for seq_chunk_addsub (WIDTH=32, CHUNK=8).
// Subtract expectations follow SEQ_ADDSUB_SUB_EN.
module tb_seq_chunk_addsub;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        cout;
    logic        ovf;

    int n_tests;
    int n_fail;

    seq_chunk_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] xa,
                          input logic [31:0] yb, input logic ci,
                          input logic o, input logic [31:0] exp_s,
                          input logic exp_c, input logic exp_v);
        int lat;
        x = xa; y = yb; cin = ci; op = o;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x = 32'hDEAD_BEEF; y = 32'hCAFE_F00D; op = ~o;
        wait_result(lat);
        check({tag, ".lat"}, 64'(lat), 64'd4);
        check({tag, ".s"}, 64'(s), 64'(exp_s));
        check({tag, ".cout"}, 64'(cout), 64'(exp_c));
        check({tag, ".ovf"}, 64'(ovf), 64'(exp_v));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int seen;
        n_tests = 0;
        n_fail  = 0;
        in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; cin = 1'b0; op = 1'b0;
        rst_n = 1'b0;
        #12;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.s", 64'(s), 64'd0);
        check("rst.cout", 64'(cout), 64'd0);
        check("rst.ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add", 32'h5555_5555, 32'h2AAA_AAAA, 1'b0, 1'b0,
               32'h7FFF_FFFF, 1'b0, 1'b0);
        run_op("addc", 32'h5555_5555, 32'h2AAA_AAAA, 1'b1, 1'b0,
               32'h8000_0000, 1'b0, 1'b1);
        run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h0000_0000, 1'b1, 1'b0);
`ifdef SEQ_ADDSUB_SUB_EN
        run_op("sub", 32'd5, 32'd7, 1'b1, 1'b1,
               32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("subeq", 32'h8000_0000, 32'd1, 1'b0, 1'b1,
               32'h7FFF_FFFF, 1'b1, 1'b1);
`else
        run_op("sub", 32'd5, 32'd7, 1'b1, 1'b1,
               32'h0000_000D, 1'b0, 1'b0);
`endif

        // Backpressure in DONE, then a new request behind it
        x = 32'h1234_5678; y = 32'h1111_1111; cin = 1'b0; op = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        check("bp.lat", 64'(lat), 64'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp.valid", 64'(out_valid), 64'd1);
            check("bp.in_ready", 64'(in_ready), 64'd0);
            check("bp.s", 64'(s), 64'h2345_6789);
            check("bp.cout", 64'(cout), 64'd0);
            check("bp.ovf", 64'(ovf), 64'd0);
        end
        x = 32'h7FFF_FFFF; y = 32'h0000_0001; cin = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("b2b.idle", 64'(in_ready), 64'd1);
        check("b2b.novalid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b.accepted", 64'(in_ready), 64'd0);
        wait_result(lat);
        check("b2b.lat", 64'(lat), 64'd4);
        check("b2b.s", 64'(s), 64'h8000_0000);
        check("b2b.cout", 64'(cout), 64'd0);
        check("b2b.ovf", 64'(ovf), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Asynchronous reset during the second RUN cycle
        x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; cin = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.in_ready", 64'(in_ready), 64'd1);
        check("arst.out_valid", 64'(out_valid), 64'd0);
        check("arst.s", 64'(s), 64'd0);
        check("arst.cout", 64'(cout), 64'd0);
        check("arst.ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("arst.no_result", 64'(seen), 64'd0);
        run_op("post", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
               32'h0000_0100, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_chunk_addsub.md
# seq_chunk_addsub

Multi-cycle, parametrised adder/subtractor that computes a WIDTH-bit result CHUNK bits per clock, carrying between chunks through a registered carry. It is the successor to the team's fixed-width combinational ripple-carry adders. It trades latency for a short critical path (one CHUNK-bit ripple chain). It sits behind a valid/ready request port and in front of a valid/ready result port, so ALU and datapath blocks can stall it.

## Interface
- WIDTH, 32, operand/result width; must be a positive multiple of CHUNK
- CHUNK, 8, bits processed per cycle; N = WIDTH/CHUNK chunk cycles per operation
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- op  input  1  0 = add, 1 = subtract (see Configuration)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  result
- cout  output  1  carry out of bit WIDTH-1 (for subtract: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid is high, the block captures x, y, op and the effective carry-in, clears the chunk counter k, and moves to RUN.
- Effective operands:
  - Add: B = y, c0 = cin.
  - Subtract: B = ~y, c0 = 1; cin is ignored.
- RUN:
  - Each cycle computes {c, s[k*CHUNK +: CHUNK]} = x chunk + B chunk + carry register.
  - The block then stores c and increments k.
  - When k = N-1 is processed, the block records cout = final carry and ovf = (carry into bit WIDTH-1) XOR cout, then moves to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1; s, cout and ovf are stable.
  - When out_ready is high, the block moves to IDLE.
  - There is no direct DONE→RUN path: a new request is accepted only in IDLE.
- Result width is exactly WIDTH; the carry beyond WIDTH appears only on cout.
- Operand registers are unaffected by changes on x, y or op after acceptance.
- s bits of chunks not yet processed in RUN are undefined to the consumer; the consumer reads s only while out_valid is high.

## Timing
- Reset (asynchronous, rst_n low):
  - State=IDLE, in_ready=1, out_valid=0, s=0, cout=0, ovf=0, k=0, carry register=0.
  - This applies immediately, including mid-RUN or in DONE. Any in-flight operation is discarded and no result is produced.
- The accept handshake occurs on the clock edge where in_valid && in_ready.
- Latency: out_valid rises after the N-th rising edge following the accept edge. With the defaults (N=4), out_valid is high during cycle 4 after accept.
- CHUNK = WIDTH gives N=1: one RUN cycle, then DONE.
- Back-to-back throughput: one result per N+2 cycles when out_ready is held high (accept, N×RUN, DONE).
- Backpressure: out_valid, s, cout and ovf hold unchanged for as long as out_ready stays low in DONE.
- If in_valid is held high during RUN or DONE it is ignored; it is accepted on the first IDLE cycle.
- The k counter is ceil(log2(N)) bits wide, minimum 1. It never wraps mid-operation.

## Configuration
- SEQ_ADDSUB_SUB_EN
  - Defined: the op input selects add/subtract as described above.
  - Not defined: the op port exists but is ignored. The block always adds (B = y, c0 = cin), and the inversion/force-carry logic is not built.
  - ovf and cout behave identically in add mode in both builds.

## Test plan
- Add without carry: WIDTH=32, CHUNK=8, x=0x55555555, y=0x2AAAAAAA, cin=0 → s=0x7FFFFFFF, cout=0, ovf=0; out_valid rises 4 edges after accept.
- Add with carry: same x and y, cin=1 → s=0x80000000, cout=0, ovf=1 (positive + positive overflow).
- Wrap-around: x=0xFFFFFFFF, y=0x00000001, cin=0 → s=0x00000000, cout=1, ovf=0. The inter-chunk carry propagates through all 4 chunks.
- Subtract (SEQ_ADDSUB_SUB_EN defined): x=5, y=7, op=1, cin=1 → s=0xFFFFFFFE, cout=0 (borrow), ovf=0; cin has no effect. Without the macro, the same stimulus gives s=0x0000000D (5+7+cin).
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE: s, cout, ovf and out_valid remain constant, and in_ready stays 0.
  - Raise out_ready with in_valid held high and a new request: the block returns to IDLE and accepts the new request on the next edge.
- Reset mid-operation: assert rst_n=0 asynchronously during the 2nd RUN cycle. Outputs go to the reset values without a clock edge. After release, no out_valid appears until a new request completes.
